// File: rtl/risc_alu_pkg.sv
// Shared op codes, FSM state type and op classification for the sequential RISC ALU.
package risc_alu_pkg;

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRA  = 4'd1;
    localparam logic [3:0] OP_SRL  = 4'd2;
    localparam logic [3:0] OP_MULU = 4'd3;
    localparam logic [3:0] OP_DIVU = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;
    localparam logic [3:0] OP_MULS = 4'd13;
    localparam logic [3:0] OP_DIVS = 4'd14;
    localparam logic [3:0] OP_RSVD = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_MULS) || (op == OP_DIVS);
    endfunction

    function automatic logic is_signed_iter_op(input logic [3:0] op);
        return (op == OP_MULS) || (op == OP_DIVS);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_DIVS);
    endfunction

endpackage

// File: rtl/risc_alu_muldiv_iter.sv
// Unsigned iterative core: shift-add multiply or restoring divide, one bit per clock.
// lo_o/hi_o hold product low/high or quotient/remainder once done_o has fired.
module risc_alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH:0]   trial_s;

    // Iteration datapath and counter next-state.
    always_comb begin
        busy_d  = busy_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        shl_s   = {hi_q, lo_q[WIDTH-1]};
        trial_s = shl_s - {1'b0, b_q};
        if (start_i) begin
            busy_d = 1'b1;
            div_d  = div_i;
            cnt_d  = {CW{1'b0}};
            hi_d   = {WIDTH{1'b0}};
            lo_d   = a_i;
            b_d    = b_i;
        end else if (busy_q) begin
            if (div_q) begin
                // A clear borrow bit means the divisor fits: keep the difference.
                if (!trial_s[WIDTH]) begin
                    hi_d = trial_s[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shl_s[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = sum_s[WIDTH:1];
                lo_d = {sum_s[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Core state registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= {CW{1'b0}};
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            b_q    <= {WIDTH{1'b0}};
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
        end
    end

    assign done_o = busy_q && (cnt_q == LAST_CNT);
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;

endmodule

// File: rtl/risc_alu_seq.sv
// Handshaked RISC ALU: single-cycle logic/arith ops plus iterative signed/unsigned
// multiply and divide, with a registered result bundle held under backpressure.
module risc_alu_seq
    import risc_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       ALU_OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result2,
    output logic             OF,
    output logic             UOF,
    output logic             Equal
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0]   result_q, result_d, result2_q, result2_d;
    logic               of_q, of_d, uof_q, uof_d, equal_q, equal_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready_s, accept_s, signed_op_s;
    logic [SHW-1:0]     shamt_s;
    logic [WIDTH:0]     add_s, sub_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_of_s, alu_uof_s;
    logic [WIDTH-1:0]   core_a_s, core_b_s, core_lo_s, core_hi_s;
    logic               core_start_s, core_done_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic               neg_s;
    logic [WIDTH-1:0]   fix_res_s, fix_res2_s;
    logic               fix_of_s, fix_uof_s;

    risc_alu_muldiv_iter #(.WIDTH(WIDTH)) u_core (
        .clk_i   (clock),
        .rst_n   (rst_n),
        .start_i (core_start_s),
        .div_i   (is_div_op(ALU_OP)),
        .a_i     (core_a_s),
        .b_i     (core_b_s),
        .done_o  (core_done_s),
        .lo_o    (core_lo_s),
        .hi_o    (core_hi_s)
    );

    // Single-cycle result and flags, straight from the presented operands.
    always_comb begin
        shamt_s   = Y[SHW-1:0];
        add_s     = {1'b0, X} + {1'b0, Y};
        sub_s     = {1'b0, X} - {1'b0, Y};
        alu_res_s = {WIDTH{1'b0}};
        alu_of_s  = 1'b0;
        alu_uof_s = 1'b0;
        case (ALU_OP)
            OP_SLL:  alu_res_s = X << shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(X) >>> shamt_s);
            OP_SRL:  alu_res_s = X >> shamt_s;
            OP_ADD: begin
                alu_res_s = add_s[WIDTH-1:0];
                alu_uof_s = add_s[WIDTH];
                alu_of_s  = (X[WIDTH-1] == Y[WIDTH-1]) && (add_s[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = sub_s[WIDTH-1:0];
                alu_uof_s = sub_s[WIDTH];
                alu_of_s  = (X[WIDTH-1] != Y[WIDTH-1]) && (sub_s[WIDTH-1] != X[WIDTH-1]);
            end
            OP_AND:  alu_res_s = X & Y;
            OP_OR:   alu_res_s = X | Y;
            OP_XOR:  alu_res_s = X ^ Y;
            OP_NOR:  alu_res_s = ~(X | Y);
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (X < Y)};
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Sign correction of the unsigned core result, using the latched operands.
    always_comb begin
        prod_s     = {core_hi_s, core_lo_s};
        neg_s      = x_q[WIDTH-1] ^ y_q[WIDTH-1];
        prod_fix_s = neg_s ? -prod_s : prod_s;
        fix_res_s  = {WIDTH{1'b0}};
        fix_res2_s = {WIDTH{1'b0}};
        fix_of_s   = 1'b0;
        fix_uof_s  = 1'b0;
        case (op_q)
            OP_MULU: begin
                fix_res_s  = core_lo_s;
                fix_res2_s = core_hi_s;
                fix_uof_s  = |core_hi_s;
            end
            OP_MULS: begin
                fix_res_s  = prod_fix_s[WIDTH-1:0];
                fix_res2_s = prod_fix_s[2*WIDTH-1:WIDTH];
                fix_of_s   = prod_fix_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix_s[WIDTH-1]}};
            end
            OP_DIVU: begin
                fix_res_s  = core_lo_s;
                fix_res2_s = core_hi_s;
            end
            OP_DIVS: begin
                if (y_q == {WIDTH{1'b0}}) begin
                    fix_res_s  = {WIDTH{1'b1}};
                    fix_res2_s = x_q;
                end else if ((x_q == MOST_NEG) && (y_q == {WIDTH{1'b1}})) begin
                    fix_res_s  = x_q;
                    fix_res2_s = {WIDTH{1'b0}};
                    fix_of_s   = 1'b1;
                end else begin
                    fix_res_s  = neg_s ? -core_lo_s : core_lo_s;
                    fix_res2_s = x_q[WIDTH-1] ? -core_hi_s : core_hi_s;
                end
            end
            default: begin
                fix_res_s  = {WIDTH{1'b0}};
                fix_res2_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Handshake, FSM next state and result-bundle next state.
    always_comb begin
        in_ready_s   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        accept_s     = in_valid && in_ready_s;
        signed_op_s  = is_signed_iter_op(ALU_OP);
        core_a_s     = (signed_op_s && X[WIDTH-1]) ? -X : X;
        core_b_s     = (signed_op_s && Y[WIDTH-1]) ? -Y : Y;
        core_start_s = 1'b0;
        state_d      = state_q;
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        result_d     = result_q;
        result2_d    = result2_q;
        of_d         = of_q;
        uof_d        = uof_q;
        equal_d      = equal_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_iter_op(ALU_OP)) begin
                    core_start_s = 1'b1;
                    op_d         = ALU_OP;
                    x_d          = X;
                    y_d          = Y;
                    state_d      = is_div_op(ALU_OP) ? ST_DIV : ST_MUL;
                end else if (accept_s) begin
                    result_d    = alu_res_s;
                    result2_d   = {WIDTH{1'b0}};
                    of_d        = alu_of_s;
                    uof_d       = alu_uof_s;
                    equal_d     = (X == Y);
                    out_valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (core_done_s) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FIX: begin
                result_d    = fix_res_s;
                result2_d   = fix_res2_s;
                of_d        = fix_of_s;
                uof_d       = fix_uof_s;
                equal_d     = (x_q == y_q);
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched operands and the result bundle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'd0;
            x_q         <= {WIDTH{1'b0}};
            y_q         <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            result2_q   <= {WIDTH{1'b0}};
            of_q        <= 1'b0;
            uof_q       <= 1'b0;
            equal_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            result_q    <= result_d;
            result2_q   <= result2_d;
            of_q        <= of_d;
            uof_q       <= uof_d;
            equal_q     <= equal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Result2   = result2_q;
    assign OF        = of_q;
    assign UOF       = uof_q;
    assign Equal     = equal_q;

endmodule

// File: tb/tb_risc_alu_seq.sv
// Directed self-checking bench for risc_alu_seq (WIDTH=32): ops, latency, backpressure, reset abort.
module tb_risc_alu_seq;
    import risc_alu_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic [3:0]   ALU_OP = 4'd0;
    logic         in_ready, out_valid, OF, UOF, Equal;
    logic [W-1:0] Result, Result2;

    int n_vec = 0;
    int n_err = 0;

    risc_alu_seq #(.WIDTH(W)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .ALU_OP    (ALU_OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Result2   (Result2),
        .OF        (OF),
        .UOF       (UOF),
        .Equal     (Equal)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready=1, wait for the bundle, check it and its latency.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat, input logic [W-1:0] er,
                          input logic [W-1:0] er2, input logic eof, input logic euof,
                          input logic eeq);
        int   n;
        logic ready_seen;
        check_val({tag, "_in_ready"}, in_ready, 1);
        ALU_OP   = op;
        X        = a;
        Y        = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid   = 1'b0;
        n          = 1;
        ready_seen = 1'b0;
        while (!out_valid && n <= 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clock);
            #1;
            n++;
        end
        if (!out_valid) begin
            check_val({tag, "_timeout"}, out_valid, 1);
            return;
        end
        check_val({tag, "_latency"}, n, lat);
        check_val({tag, "_busy_ready"}, ready_seen, 0);
        check_val({tag, "_Result"}, Result, er);
        check_val({tag, "_Result2"}, Result2, er2);
        check_val({tag, "_OF"}, OF, eof);
        check_val({tag, "_UOF"}, UOF, euof);
        check_val({tag, "_Equal"}, Equal, eeq);
        @(posedge clock);
        #1;
        check_val({tag, "_drop"}, out_valid, 0);
    endtask

    initial begin
        int mul_lat;
        int stale;
        mul_lat = W + 2;

        repeat (3) @(posedge clock);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_Result", Result, 0);
        check_val("rst_Result2", Result2, 0);
        check_val("rst_flags", {OF, UOF, Equal}, 0);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        check_val("rst_in_ready", in_ready, 1);

        run_op("add_carry", OP_ADD, 32'd3224109733, 32'd3759153164, 1, 32'd2688295601, 32'd0, 1'b0, 1'b1, 1'b0);
        run_op("add_of",    OP_ADD, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("sub",       OP_SUB, 32'd10, 32'd3, 1, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("sub_of",    OP_SUB, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("sll",       OP_SLL, 32'd1, 32'd33, 1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("sra",       OP_SRA, 32'h8000_0000, 32'd4, 1, 32'hF800_0000, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("srl",       OP_SRL, 32'h8000_0000, 32'd4, 1, 32'h0800_0000, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("and",       OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1, 32'h00F0_000F, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("or",        OP_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1, 32'hFFF0_0FFF, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("xor",       OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1, 32'hFF00_0FF0, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("nor",       OP_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1, 32'h000F_F000, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("xor_eq",    OP_XOR, 32'h1234_5678, 32'h1234_5678, 1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        run_op("slt",       OP_SLT, 32'd1256981157, 32'd2147484852, 1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("sltu",      OP_SLTU, 32'd1256981157, 32'd2147484852, 1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("rsvd",      OP_RSVD, 32'd5, 32'd5, 1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        run_op("mulu",      OP_MULU, 32'd24, 32'd453, mul_lat, 32'd10872, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op("mulu_ovf",  OP_MULU, 32'hFFFF_FFFF, 32'd2, mul_lat, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1, 1'b0);
        run_op("muls_neg",  OP_MULS, 32'hFFFF_FFFD, 32'd5, mul_lat, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("muls_ovf",  OP_MULS, 32'h0001_0000, 32'h0001_0000, mul_lat, 32'd0, 32'd1, 1'b1, 1'b0, 1'b1);
        run_op("divu",      OP_DIVU, 32'd677, 32'd12, mul_lat, 32'd56, 32'd5, 1'b0, 1'b0, 1'b0);
        run_op("divs",      OP_DIVS, 32'hFFFF_FFF9, 32'd2, mul_lat, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("divs_negy", OP_DIVS, 32'd7, 32'hFFFF_FFFE, mul_lat, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 1'b0);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, mul_lat, 32'hFFFF_FFFF, 32'd100, 1'b0, 1'b0, 1'b0);
        run_op("divs_zero", OP_DIVS, 32'hFFFF_FFFB, 32'd0, mul_lat, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0);
        run_op("divs_min",  OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, mul_lat, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure: hold ADD 1+2, then consume it while a SUB loads on the same edge.
        out_ready = 1'b0;
        ALU_OP    = OP_ADD;
        X         = 32'd1;
        Y         = 32'd2;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check_val("bp_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_hold_Result", Result, 3);
            check_val("bp_hold_in_ready", in_ready, 0);
            @(posedge clock);
            #1;
        end
        check_val("bp_still_valid", out_valid, 1);
        out_ready = 1'b1;
        ALU_OP    = OP_SUB;
        X         = 32'd5;
        Y         = 32'd7;
        in_valid  = 1'b1;
        #1;
        check_val("bp_ready_on_consume", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check_val("bp_next_valid", out_valid, 1);
        check_val("bp_next_Result", Result, 32'hFFFF_FFFE);
        check_val("bp_next_UOF", UOF, 1);
        check_val("bp_next_OF", OF, 0);
        @(posedge clock);
        #1;
        check_val("bp_next_drop", out_valid, 0);

        // Reset asserted ten cycles into a MULS aborts it with nothing emitted.
        ALU_OP   = OP_MULS;
        X        = 32'hFFFF_FFFD;
        Y        = 32'd5;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check_val("abort_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_Result", Result, 0);
        check_val("abort_Result2", Result2, 0);
        check_val("abort_flags", {OF, UOF, Equal}, 0);
        check_val("abort_state", dut.state_q, ST_IDLE);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        #1;
        check_val("abort_in_ready", in_ready, 1);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) stale++;
        end
        check_val("abort_no_stale", stale, 0);
        run_op("muls_after", OP_MULS, 32'hFFFF_FFFD, 32'd5, mul_lat, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
